spu_result_pipe: RTL and testbench

//  Writeback side of the even-pipe execute unit. Captures each EX result with its RT address and latency code.

---
 rtl/spu_pkg.sv | 16 +
 rtl/spu_fwd_match.sv | 30 +++
 rtl/spu_result_pipe.sv | 118 +++++++++++
 tb/tb_spu_result_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared constants and types for the SPU even-pipe result writeback path.
package spu_pkg;

  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 7;
  localparam int NUM_FWD = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;

  typedef logic [2:0] latency_t;

endpackage

// File: rtl/spu_fwd_match.sv
// One forwarding lookup port: priority match of an RT address over the
// in-flight result slots. The highest matching slot wins because it is the
// last one to write back, so it holds the youngest value for that register.
// Only built when SPU_RESULT_FWD_EN is defined.
`ifdef SPU_RESULT_FWD_EN
module spu_fwd_match
  import spu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  pipe_entry_t       slots [DEPTH],
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Scan low to high so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].valid && (slots[i].rt == lookup_addr)) begin
        hit  = 1'b1;
        data = slots[i].data;
      end
    end
  end

endmodule
`endif

// File: rtl/spu_result_pipe.sv
// Writeback delay pipe for the even-pipe execute unit. A result issued with
// latency code L lands in slot L and shifts down one slot per cycle, reaching
// the register-file write port (slot 0) L+1 cycles after issue.
// Optional feature macro: SPU_RESULT_FWD_EN adds the operand forwarding ports.
module spu_result_pipe
  import spu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_result,
  input  latency_t          in_latency,
  input  logic              flush,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              collision_err,
  output logic              lat_err
`ifdef SPU_RESULT_FWD_EN
  ,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data
`endif
);

  pipe_entry_t slot_q [DEPTH];
  pipe_entry_t slot_d [DEPTH];
  logic        collision_q, collision_d;
  logic        lat_err_q, lat_err_d;

  latency_t    lat_clamped;
  logic        lat_over;
  logic        slot_free;
  logic        accept;

  // Clamp out-of-range latency codes to the deepest slot.
  always_comb begin
    lat_over    = (int'(in_latency) > (DEPTH - 1));
    lat_clamped = lat_over ? latency_t'(DEPTH - 1) : in_latency;
  end

  // Target slot is free when the entry about to shift into it is empty.
  always_comb begin
    slot_free = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      if ((int'(lat_clamped) + 1) == i) slot_free = !slot_q[i].valid;
    end
    in_ready = slot_free && !flush;
    accept   = in_valid && in_ready;
  end

  // Next pipe state: shift down, optionally kill everything, then insert.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
    slot_d[DEPTH-1] = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i].valid = 1'b0;
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(lat_clamped)) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].rt    = in_rt;
          slot_d[i].data  = in_result;
        end
      end
    end
  end

  // Error flags: collision is sticky, latency error is a one-cycle pulse.
  always_comb begin
    collision_d = collision_q || (in_valid && !in_ready && !flush);
    lat_err_d   = accept && lat_over;
  end

  // Pipe and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      collision_q <= 1'b0;
      lat_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      collision_q <= collision_d;
      lat_err_q   <= lat_err_d;
    end
  end

  // Any in-flight entry keeps the unit busy.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | slot_q[i].valid;
  end

  assign wb_en         = slot_q[0].valid;
  assign wb_addr       = slot_q[0].rt;
  assign wb_data       = slot_q[0].data;
  assign collision_err = collision_q;
  assign lat_err       = lat_err_q;

`ifdef SPU_RESULT_FWD_EN
  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    spu_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
      .slots       (slot_q),
      .lookup_addr (fwd_addr[k*ADDR_W +: ADDR_W]),
      .hit         (fwd_hit[k]),
      .data        (fwd_data[k*DATA_W +: DATA_W])
    );
  end
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
module tb_spu_result_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [6:0]   in_rt = '0;
  logic [127:0] in_result = '0;
  logic [2:0]   in_latency = '0;
  logic         flush = 1'b0;

  logic         in_ready, wb_en, busy, collision_err, lat_err;
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;
  logic         in_ready4, wb_en4, busy4, collision_err4, lat_err4;
  logic [6:0]   wb_addr4;
  logic [127:0] wb_data4;
`ifdef SPU_RESULT_FWD_EN
  logic [20:0]  fwd_addr = '0;
  logic [2:0]   fwd_hit, fwd_hit4;
  logic [383:0] fwd_data, fwd_data4;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spu_result_pipe #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rt(in_rt), .in_result(in_result), .in_latency(in_latency), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
    .collision_err(collision_err), .lat_err(lat_err)
`ifdef SPU_RESULT_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  spu_result_pipe #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_rt(in_rt), .in_result(in_result), .in_latency(in_latency), .flush(flush),
    .wb_en(wb_en4), .wb_addr(wb_addr4), .wb_data(wb_data4), .busy(busy4),
    .collision_err(collision_err4), .lat_err(lat_err4)
`ifdef SPU_RESULT_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit4), .fwd_data(fwd_data4)
`endif
  );

  typedef struct {
    logic         v;
    logic [6:0]   rt;
    logic [127:0] data;
    logic [2:0]   lat;
    logic         e_en;
    logic [6:0]   e_addr;
    logic [127:0] e_data;
    logic         e_ready;
    logic         e_busy;
    logic         e_coll;
  } vec_t;

  vec_t tbl [20];

  localparam logic [127:0] D1 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rt = '0; in_result = '0; in_latency = 3'd7; flush = 1'b0;
  endtask

  task automatic issue(input logic [6:0] rt, input logic [127:0] d, input logic [2:0] l);
    in_valid = 1'b1; in_rt = rt; in_result = d; in_latency = l;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [6:0] rt, input logic [127:0] d,
                              input logic [2:0] l, input logic e_en, input logic [6:0] e_addr,
                              input logic [127:0] e_data, input logic e_ready, input logic e_busy,
                              input logic e_coll);
    vec_t r;
    r.v = v; r.rt = rt; r.data = d; r.lat = l; r.e_en = e_en; r.e_addr = e_addr;
    r.e_data = e_data; r.e_ready = e_ready; r.e_busy = e_busy; r.e_coll = e_coll;
    return r;
  endfunction

  initial begin
    // One row per cycle: inputs driven in that cycle and outputs seen in it.
    // rows 0-4: single issue L=2 writes back 3 cycles later
    tbl[0]  = mk(1, 7'd5,  D1,     3'd2, 0, 0,      0,      1, 0, 0);
    tbl[1]  = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 0);
    tbl[2]  = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 0);
    tbl[3]  = mk(0, 0,     0,      3'd7, 1, 7'd5,   D1,     1, 1, 0);
    tbl[4]  = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 0, 0);
    // rows 5-10: four back-to-back L=0 issues, written in order
    tbl[5]  = mk(1, 7'd10, 128'hA0, 3'd0, 0, 0,     0,      1, 0, 0);
    tbl[6]  = mk(1, 7'd11, 128'hA1, 3'd0, 1, 7'd10, 128'hA0, 1, 1, 0);
    tbl[7]  = mk(1, 7'd12, 128'hA2, 3'd0, 1, 7'd11, 128'hA1, 1, 1, 0);
    tbl[8]  = mk(1, 7'd13, 128'hA3, 3'd0, 1, 7'd12, 128'hA2, 1, 1, 0);
    tbl[9]  = mk(0, 0,     0,      3'd7, 1, 7'd13, 128'hA3, 1, 1, 0);
    tbl[10] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 0, 0);
    // rows 11-19: L=6 then a colliding L=2 issue four cycles later
    tbl[11] = mk(1, 7'd1,  128'hB1, 3'd6, 0, 0,     0,      1, 0, 0);
    tbl[12] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 0);
    tbl[13] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 0);
    tbl[14] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 0);
    tbl[15] = mk(1, 7'd2,  128'hB2, 3'd2, 0, 0,     0,      0, 1, 0);
    tbl[16] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 1);
    tbl[17] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 1, 1);
    tbl[18] = mk(0, 0,     0,      3'd7, 1, 7'd1,   128'hB1, 1, 1, 1);
    tbl[19] = mk(0, 0,     0,      3'd7, 0, 0,      0,      1, 0, 1);

    do_reset();
    chk("reset_wb_en", wb_en, 0);
    chk("reset_wb_addr", wb_addr, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_collision", collision_err, 0);
    chk("reset_lat_err", lat_err, 0);

    for (int r = 0; r < 20; r++) begin
      in_valid = tbl[r].v; in_rt = tbl[r].rt; in_result = tbl[r].data;
      in_latency = tbl[r].lat; flush = 1'b0;
      #1;
      chk($sformatf("row%0d_wb_en", r), wb_en, tbl[r].e_en);
      if (tbl[r].e_en) begin
        chk($sformatf("row%0d_wb_addr", r), wb_addr, tbl[r].e_addr);
        chk($sformatf("row%0d_wb_data", r), wb_data, tbl[r].e_data);
      end
      chk($sformatf("row%0d_in_ready", r), in_ready, tbl[r].e_ready);
      chk($sformatf("row%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("row%0d_collision", r), collision_err, tbl[r].e_coll);
      chk($sformatf("row%0d_lat_err", r), lat_err, 0);
      tick();
    end
    idle_inputs();

    // Async reset while results are in flight: outputs clear at once and
    // nothing stale is written after release.
    issue(7'd50, 128'hC0, 3'd1); tick();
    issue(7'd51, 128'hC1, 3'd5); tick();
    idle_inputs(); #1;
    chk("midrst_pre_wb_en", wb_en, 1);
    chk("midrst_pre_wb_addr", wb_addr, 7'd50);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wb_en", wb_en, 0);
    chk("midrst_wb_addr", wb_addr, 0);
    chk("midrst_wb_data", wb_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_collision", collision_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("postrst_c%0d_wb_en", c), wb_en, 0);
      tick();
    end

    // Flush: slot 0 still writes that cycle, everything else is killed,
    // same-cycle input discarded and not treated as a collision.
    issue(7'd30, 128'hD0, 3'd2); tick();
    issue(7'd31, 128'hD1, 3'd3); tick();
    idle_inputs(); tick();
    issue(7'd32, 128'hD2, 3'd0); flush = 1'b1; #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_wb_en", wb_en, 1);
    chk("flush_wb_addr", wb_addr, 7'd30);
    chk("flush_wb_data", wb_data, 128'hD0);
    tick();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("postflush_c%0d_wb_en", c), wb_en, 0);
      chk($sformatf("postflush_c%0d_busy", c), busy, 0);
      tick();
    end
    chk("flush_no_collision", collision_err, 0);

    // Latency clamp on the DEPTH=4 instance.
    do_reset();
    issue(7'd40, 128'hE0, 3'd7); #1;
    chk("clamp_in_ready4", in_ready4, 1);
    tick();
    idle_inputs(); #1;
    chk("clamp_lat_err4_c1", lat_err4, 1);
    chk("clamp_lat_err8_c1", lat_err, 0);
    tick();
    chk("clamp_lat_err4_c2", lat_err4, 0);
    tick();
    chk("clamp_wb_en4_c3", wb_en4, 0);
    tick();
    chk("clamp_wb_en4_c4", wb_en4, 1);
    chk("clamp_wb_addr4_c4", wb_addr4, 7'd40);
    chk("clamp_wb_data4_c4", wb_data4, 128'hE0);
    tick();
    chk("clamp_wb_en4_c5", wb_en4, 0);

`ifdef SPU_RESULT_FWD_EN
    // Forwarding: rt=9 in slots 1 (A) and 3 (B); highest slot wins.
    do_reset();
    issue(7'd9, 128'hAAAA, 3'd2); tick();
    issue(7'd9, 128'hBBBB, 3'd3); tick();
    idle_inputs();
    fwd_addr = {7'd9, 7'd8, 7'd9}; #1;
    chk("fwd_p0_hit", fwd_hit[0], 1);
    chk("fwd_p0_data", fwd_data[127:0], 128'hBBBB);
    chk("fwd_p1_hit", fwd_hit[1], 0);
    chk("fwd_p1_data", fwd_data[255:128], 0);
    chk("fwd_p2_data", fwd_data[383:256], 128'hBBBB);
    tick(); tick(); tick();
    chk("fwd_slot0_wb_en", wb_en, 1);
    chk("fwd_slot0_hit", fwd_hit[0], 1);
    chk("fwd_slot0_data", fwd_data[127:0], 128'hBBBB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
